// File: rtl/caleidoscope_timebase.sv
// Per-frame animation parameter sequencer for the caleidoscope pixel generator.
// Debounces mode switches, detects VBLANK rises and publishes TIME/TIME_TRI/TIME_CONST atomically.
`timescale 1ns/1ps
module caleidoscope_timebase #(
    parameter int          DEBOUNCE_CYCLES = 250000,
    parameter logic [23:0] TC_BASE         = 24'h000200,
    parameter int          TC_SHIFT        = 3
) (
    input  logic        CLK_25MHz,
    input  logic        RESET,
    input  logic        VBLANK,
    input  logic [2:0]  SWITCH,
    output logic [15:0] TIME,
    output logic [15:0] TIME_TRI,
    output logic [23:0] TIME_CONST,
    output logic        PARAM_STB,
    output logic [15:0] FRAME_CNT,
    output logic [2:0]  SW_DEB
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_STEP    = 3'd1,
        S_TRI     = 3'd2,
        S_CONST   = 3'd3,
        S_PUBLISH = 3'd4
    } state_t;

    // Synchronizers; the VBLANK chain resets high so a level already high at reset is not an edge
    logic       r_vb_s1;
    logic       r_vb_s2;
    logic       r_vb_hist;
    logic       r_vb_rise;
    logic [2:0] r_sw_s1;
    logic [2:0] r_sw_s2;

    always_ff @(posedge CLK_25MHz) begin
        if (RESET) begin
            r_vb_s1   <= 1'b1;
            r_vb_s2   <= 1'b1;
            r_vb_hist <= 1'b1;
            r_vb_rise <= 1'b0;
            r_sw_s1   <= 3'b000;
            r_sw_s2   <= 3'b000;
        end else begin
            r_vb_s1   <= VBLANK;
            r_vb_s2   <= r_vb_s1;
            r_vb_hist <= r_vb_s2;
            r_vb_rise <= r_vb_s2 & ~r_vb_hist;
            r_sw_s1   <= SWITCH;
            r_sw_s2   <= r_sw_s1;
        end
    end

    logic [2:0] w_sw_deb;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_deb
            logic [CNT_W-1:0] r_cnt;
            logic             r_deb;

            always_ff @(posedge CLK_25MHz) begin
                if (RESET) begin
                    r_cnt <= '0;
                    r_deb <= 1'b0;
                end else if (r_sw_s2[gi] == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_deb <= r_sw_s2[gi];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_sw_deb[gi] = r_deb;
        end
    endgenerate

    state_t r_state;
    state_t w_state_next;

    always_ff @(posedge CLK_25MHz) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // A rise seen outside IDLE is simply dropped
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (r_vb_rise) w_state_next = S_STEP;
            S_STEP:    w_state_next = S_TRI;
            S_TRI:     w_state_next = S_CONST;
            S_CONST:   w_state_next = S_PUBLISH;
            S_PUBLISH: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    logic w_ld_mode;
    logic w_ld_t;
    logic w_ld_tri;
    logic w_ld_c;
    logic w_publish;

    always_comb begin
        w_ld_mode = 1'b0;
        w_ld_t    = 1'b0;
        w_ld_tri  = 1'b0;
        w_ld_c    = 1'b0;
        w_publish = 1'b0;
        case (r_state)
            S_IDLE:    w_ld_mode = r_vb_rise;
            S_STEP:    w_ld_t    = 1'b1;
            S_TRI:     w_ld_tri  = 1'b1;
            S_CONST:   w_ld_c    = 1'b1;
            S_PUBLISH: w_publish = 1'b1;
            default:   w_publish = 1'b0;
        endcase
    end

    logic [2:0]  r_mode;
    logic [15:0] r_t_nxt;
    logic [15:0] r_tri;
    logic [23:0] r_c;
    logic [15:0] r_time;
    logic [15:0] r_time_tri;
    logic [23:0] r_time_const;
    logic        r_stb;
    logic [15:0] r_frame_cnt;

    logic [15:0] w_inc;
    logic [15:0] w_t_sum;
    logic [15:0] w_t_step;
    logic [15:0] w_tri;
    logic [23:0] w_tri_sh;
    logic [23:0] w_c;

    // Triangle subtraction deliberately wraps once TIME exceeds 0xFF in unlimited mode
    always_comb begin
        w_inc    = r_mode[1] ? 16'd2 : 16'd1;
        w_t_sum  = r_time + w_inc;
        if (r_mode[0])      w_t_step = r_time;
        else if (r_mode[2]) w_t_step = w_t_sum;
        else                w_t_step = {8'h00, w_t_sum[7:0]};
        w_tri    = (r_t_nxt >= 16'h0080) ? (16'h00FF - r_t_nxt) : r_t_nxt;
        w_tri_sh = {8'h00, r_tri} << TC_SHIFT;
        w_c      = TC_BASE - w_tri_sh;
    end

    always_ff @(posedge CLK_25MHz) begin
        if (RESET) begin
            r_mode       <= 3'b000;
            r_t_nxt      <= 16'h0000;
            r_tri        <= 16'h0000;
            r_c          <= TC_BASE;
            r_time       <= 16'h0000;
            r_time_tri   <= 16'h0000;
            r_time_const <= TC_BASE;
            r_stb        <= 1'b0;
            r_frame_cnt  <= 16'h0000;
        end else begin
            r_stb <= w_publish;
            if (w_ld_mode) r_mode  <= w_sw_deb;
            if (w_ld_t)    r_t_nxt <= w_t_step;
            if (w_ld_tri)  r_tri   <= w_tri;
            if (w_ld_c)    r_c     <= w_c;
            if (w_publish) begin
                r_time       <= r_t_nxt;
                r_time_tri   <= r_tri;
                r_time_const <= r_c;
                r_frame_cnt  <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign TIME       = r_time;
    assign TIME_TRI   = r_time_tri;
    assign TIME_CONST = r_time_const;
    assign PARAM_STB  = r_stb;
    assign FRAME_CNT  = r_frame_cnt;
    assign SW_DEB     = w_sw_deb;

endmodule
